// File: rtl/moore_seq_gen.sv
// Serial pattern transmitter: sends PATTERN MSB-first `count` times, each copy
// followed by GAP forced-zero bit times, with a one-cycle done pulse at the end.
module moore_seq_gen #(
  parameter int unsigned       PAT_W   = 5,
  parameter logic [PAT_W-1:0]  PATTERN = 5'b11111,
  parameter int unsigned       GAP     = 1,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned GAP_W = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] idx_dec;
  logic             last_rep;

  assign idx_dec  = idx_q - IDX_W'(1);
  // rep_q counts patterns still to finish, including the one in flight
  assign last_rep = (rep_q == CNT_W'(1));

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; outputs are decoded from the state being entered
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d = S_SEND;
            rep_d   = count;
            idx_d   = IDX_LAST;
            out_d   = PATTERN[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          rep_d   = '0;
          gap_d   = '0;
        end else if (idx_q != '0) begin
          idx_d   = idx_dec;
          out_d   = PATTERN[idx_dec];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (GAP != 0) begin
          state_d = S_GAP;
          rep_d   = rep_q - CNT_W'(1);
          gap_d   = GAP_LAST;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (last_rep) begin
          state_d = S_DONE;
          rep_d   = '0;
          done_d  = 1'b1;
        end else begin
          rep_d   = rep_q - CNT_W'(1);
          idx_d   = IDX_LAST;
          out_d   = PATTERN[PAT_W-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          rep_d   = '0;
          gap_d   = '0;
        end else if (gap_q != '0) begin
          gap_d   = gap_q - GAP_W'(1);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (rep_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SEND;
          idx_d   = IDX_LAST;
          out_d   = PATTERN[PAT_W-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Scoreboard bench for moore_seq_gen: default 5-bit/gap-1 instance plus a
// 4'b1011 / gap-0 instance; every cycle's {out,out_valid,busy,done} is checked.
module tb_moore_seq_gen;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_A = 1;
  localparam logic [4:0]  PAT_A = 5'b11111;
  localparam logic [3:0]  PAT_B = 4'b1011;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_a, abort_a, start_b, abort_b;
  logic [CNT_W-1:0] count_a, count_b;
  logic             out_a, valid_a, busy_a, done_a;
  logic             out_b, valid_b, busy_b, done_b;

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int total = 0;
  int bad   = 0;
  int fires = 0;
  int ones  = 0;

  always #5 clk = ~clk;

  moore_seq_gen u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start_a),
    .count     (count_a),
    .abort     (abort_a),
    .out       (out_a),
    .out_valid (valid_a),
    .busy      (busy_a),
    .done      (done_a)
  );

  moore_seq_gen #(
    .PAT_W   (4),
    .PATTERN (4'b1011),
    .GAP     (0),
    .CNT_W   (CNT_W)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start_b),
    .count     (count_b),
    .abort     (abort_b),
    .out       (out_b),
    .out_valid (valid_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected {out,out_valid,busy,done} per cycle after the accepting edge
  task automatic push_a(input int n);
    logic [4:0] p;
    p = PAT_A;
    for (int r = 0; r < n; r++) begin
      for (int i = 4; i >= 0; i--) qa.push_back({p[i], 3'b110});
      for (int g = 0; g < int'(GAP_A); g++) qa.push_back(4'b0110);
    end
    qa.push_back(4'b0001);
  endtask

  task automatic push_b(input int n);
    logic [3:0] p;
    p = PAT_B;
    for (int r = 0; r < n; r++)
      for (int i = 3; i >= 0; i--) qb.push_back({p[i], 3'b110});
    qb.push_back(4'b0001);
  endtask

  task automatic step();
    logic [3:0] ea, eb;
    @(posedge clk);
    #1;
    ea = (qa.size() != 0) ? qa.pop_front() : 4'b0000;
    eb = (qb.size() != 0) ? qb.pop_front() : 4'b0000;
    check("a_obs", 32'({out_a, valid_a, busy_a, done_a}), 32'(ea));
    check("b_obs", 32'({out_b, valid_b, busy_b, done_b}), 32'(eb));
    if (valid_a) begin
      if (out_a) begin
        ones++;
        if (ones == 5) begin
          fires++;
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
  endtask

  task automatic send_a(input int n);
    start_a = 1'b1;
    count_a = CNT_W'(n);
    if (n == 0) qa.push_back(4'b0001);
    else        push_a(n);
    step();
    start_a = 1'b0;
    count_a = CNT_W'($urandom);
  endtask

  task automatic send_b(input int n);
    start_b = 1'b1;
    count_b = CNT_W'(n);
    push_b(n);
    step();
    start_b = 1'b0;
    count_b = CNT_W'($urandom);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      step();
    end
    check("drain_a", 32'(qa.size()), 32'd0);
    check("drain_b", 32'(qb.size()), 32'd0);
    step();
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    abort_a = 1'b0;
    count_a = '0;
    start_b = 1'b0;
    abort_b = 1'b0;
    count_b = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", 32'({out_a, valid_a, busy_a, done_a}), 32'd0);
    check("rst_b", 32'({out_b, valid_b, busy_b, done_b}), 32'd0);
    #3 reset = 1'b1;
    repeat (2) step();

    // count=1, then start held while DONE is sampled must be ignored
    send_a(1);
    repeat (6) step();
    start_a = 1'b1;
    count_a = CNT_W'(1);
    step();
    start_a = 1'b0;
    repeat (2) step();

    // 1011 pattern, no gap, two repeats
    send_b(2);
    drain(20);

    // three repeats seen by a five-ones non-overlapping detector
    fires = 0;
    ones  = 0;
    send_a(3);
    drain(40);
    check("det_fires", 32'(fires), 32'd3);

    // count=0 goes straight to the done pulse
    send_a(0);
    drain(5);

    // re-pulsed start during an active transfer is dropped
    send_a(1);
    repeat (2) step();
    start_a = 1'b1;
    count_a = CNT_W'(5);
    step();
    start_a = 1'b0;
    drain(20);

    // abort during bit 3 of repeat 2, then an immediate restart
    send_a(4);
    repeat (7) step();
    abort_a = 1'b1;
    qa.delete();
    step();
    abort_a = 1'b0;
    send_a(1);
    drain(20);

    // start wins over abort in IDLE
    abort_a = 1'b1;
    send_a(2);
    abort_a = 1'b0;
    drain(30);

    // async reset mid-transfer, between clock edges
    send_a(3);
    send_b(2);
    repeat (2) step();
    #2 reset = 1'b0;
    #1;
    check("rst_async_a", 32'({out_a, valid_a, busy_a, done_a}), 32'd0);
    check("rst_async_b", 32'({out_b, valid_b, busy_b, done_b}), 32'd0);
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    check("rst_hold_a", 32'({out_a, valid_a, busy_a, done_a}), 32'd0);
    #3 reset = 1'b1;
    repeat (4) step();
    send_a(1);
    send_b(1);
    drain(20);

    // maximum repeat count must not wrap
    send_a(255);
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
